sdc_clk_divider: RTL and testbench

SDC_CLK_DIVIDER -- requirements
Module: sdc_clk_divider

---
 rtl/sdc_clk_divider.sv | 134 +++++++++++++
 tb/tb_sdc_clk_divider.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_clk_divider.sv
// Multi-channel SD clock divider: per-channel divided level with rise/fall enable strobes.
// Define SDC_CLKDIV_STOP_EN to build the per-channel stop (park-low) state machine.
module sdc_clk_divider #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DIV_BITS  = 8,
  parameter int unsigned RESET_DIV = 255
) (
  input  logic                         sd_clk_in,
  input  logic                         sd_rst_n,
  input  logic [CHANNELS*DIV_BITS-1:0] div_in,
  input  logic [CHANNELS-1:0]          stop_req,
  output logic [CHANNELS-1:0]          clk_level,
  output logic [CHANNELS-1:0]          ce_rise,
  output logic [CHANNELS-1:0]          ce_fall,
  output logic [CHANNELS-1:0]          stopped,
  output logic [CHANNELS*DIV_BITS-1:0] div_active
);

  localparam logic [DIV_BITS-1:0] ResetDiv = DIV_BITS'(RESET_DIV);

`ifdef SDC_CLKDIV_STOP_EN
  typedef enum logic [0:0] {StRun, StStopped} state_e;
`else
  logic unused_stop_req;
  assign unused_stop_req = ^stop_req;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DIV_BITS-1:0] div_req;
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic                lvl_q, lvl_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                at_end;

    assign div_req = div_in[k*DIV_BITS +: DIV_BITS];
    // Last cycle of the current half-period.
    assign at_end  = (cnt_q == div_q);

`ifdef SDC_CLKDIV_STOP_EN
    state_e state_q, state_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
        StRun: begin
          if (!at_end) begin
            cnt_d = cnt_q + DIV_BITS'(1);
          end else begin
            cnt_d = '0;
            if (lvl_q) begin
              lvl_d  = 1'b0;
              fall_d = 1'b1;
              div_d  = div_req;
            end else if (stop_req[k]) begin
              // Park instead of rising; a high phase is never cut short.
              state_d = StStopped;
            end else begin
              lvl_d  = 1'b1;
              rise_d = 1'b1;
            end
          end
        end
        StStopped: begin
          cnt_d = '0;
          div_d = div_req;
          if (!stop_req[k]) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end

    always_ff @(posedge sd_clk_in or negedge sd_rst_n) begin
      if (!sd_rst_n) begin
        state_q <= StRun;
      end else begin
        state_q <= state_d;
      end
    end

    assign stopped[k] = (state_q == StStopped);
`else
    always_comb begin
      cnt_d  = cnt_q + DIV_BITS'(1);
      div_d  = div_q;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (at_end) begin
        cnt_d  = '0;
        lvl_d  = ~lvl_q;
        rise_d = ~lvl_q;
        fall_d = lvl_q;
        // New divisor takes effect only at the full-period boundary.
        if (lvl_q) begin
          div_d = div_req;
        end
      end
    end

    assign stopped[k] = 1'b0;
`endif

    always_ff @(posedge sd_clk_in or negedge sd_rst_n) begin
      if (!sd_rst_n) begin
        cnt_q  <= '0;
        div_q  <= ResetDiv;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        lvl_q  <= lvl_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign clk_level[k]                     = lvl_q;
    assign ce_rise[k]                       = rise_q;
    assign ce_fall[k]                       = fall_q;
    assign div_active[k*DIV_BITS +: DIV_BITS] = div_q;
  end

endmodule

// File: tb/tb_sdc_clk_divider.sv
// Self-checking bench for sdc_clk_divider: directed sequences, a divisor table and
// randomized stimulus against a phase-countdown reference model.
module tb_sdc_clk_divider;

  localparam int CH = 2;
  localparam int DB = 8;
`ifdef SDC_CLKDIV_STOP_EN
  localparam bit StopEn = 1'b1;
`else
  localparam bit StopEn = 1'b0;
`endif

  logic             sd_clk_in = 1'b0;
  logic             sd_rst_n;
  logic [CH*DB-1:0] div_in;
  logic [CH-1:0]    stop_req;
  logic [CH-1:0]    clk_level, ce_rise, ce_fall, stopped;
  logic [CH*DB-1:0] div_active;

  int checks = 0;
  int fails  = 0;

  sdc_clk_divider #(
    .CHANNELS (CH),
    .DIV_BITS (DB),
    .RESET_DIV(255)
  ) u_dut (
    .sd_clk_in (sd_clk_in),
    .sd_rst_n  (sd_rst_n),
    .div_in    (div_in),
    .stop_req  (stop_req),
    .clk_level (clk_level),
    .ce_rise   (ce_rise),
    .ce_fall   (ce_fall),
    .stopped   (stopped),
    .div_active(div_active)
  );

  always #5 sd_clk_in = ~sd_clk_in;

  // Reference model: each phase lasts divisor+1 cycles, counted down.
  int m_lvl[CH], m_rise[CH], m_fall[CH], m_park[CH], m_div[CH], m_rem[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_lvl[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_park[c] = 0;
      m_div[c] = 255; m_rem[c] = 256;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int d_in;
      d_in = int'(div_in[c*DB +: DB]);
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (m_park[c] != 0) begin
        m_div[c] = d_in;
        if (!stop_req[c]) begin
          m_park[c] = 0;
          m_rem[c]  = m_div[c] + 1;
        end
      end else begin
        m_rem[c] = m_rem[c] - 1;
        if (m_rem[c] == 0) begin
          if (m_lvl[c] != 0) begin
            m_lvl[c] = 0; m_fall[c] = 1; m_div[c] = d_in; m_rem[c] = m_div[c] + 1;
          end else if (StopEn && stop_req[c]) begin
            m_park[c] = 1;
          end else begin
            m_lvl[c] = 1; m_rise[c] = 1; m_rem[c] = m_div[c] + 1;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_strobe(input int ch, input bit rise, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(posedge sd_clk_in);
      #1;
      n++;
      seen = rise ? ce_rise[ch] : ce_fall[ch];
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL wait_%s ch%0d: no strobe in %0d cycles, required one",
               rise ? "rise" : "fall", ch, n);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sd_clk_in or negedge sd_rst_n);
      if (!sd_rst_n) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      logic [CH-1:0]    e_lvl, e_rise, e_fall, e_stop;
      logic [CH*DB-1:0] e_div;
      @(negedge sd_clk_in);
      for (int c = 0; c < CH; c++) begin
        e_lvl[c]  = (m_lvl[c] != 0);
        e_rise[c] = (m_rise[c] != 0);
        e_fall[c] = (m_fall[c] != 0);
        e_stop[c] = (m_park[c] != 0);
        e_div[c*DB +: DB] = DB'(m_div[c]);
      end
      check("mon_clk_level", 64'(clk_level), 64'(e_lvl));
      check("mon_ce_rise", 64'(ce_rise), 64'(e_rise));
      check("mon_ce_fall", 64'(ce_fall), 64'(e_fall));
      check("mon_stopped", 64'(stopped), 64'(e_stop));
      check("mon_div_active", 64'(div_active), 64'(e_div));
    end
  end

  typedef struct {
    logic [DB-1:0] d0;
    logic [DB-1:0] d1;
    int            per0;
    int            per1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, lo, hi, cnt;
    tbl[0] = '{d0: 8'd0,   d1: 8'd3, per0: 2,   per1: 8};
    tbl[1] = '{d0: 8'd3,   d1: 8'd0, per0: 8,   per1: 2};
    tbl[2] = '{d0: 8'd1,   d1: 8'd7, per0: 4,   per1: 16};
    tbl[3] = '{d0: 8'd5,   d1: 8'd2, per0: 12,  per1: 6};
    tbl[4] = '{d0: 8'd255, d1: 8'd1, per0: 512, per1: 4};

    sd_rst_n = 1'b1;
    div_in   = {8'd0, 8'd3};
    stop_req = '0;
    #2 sd_rst_n = 1'b0;

    // Reset values.
    repeat (3) @(posedge sd_clk_in);
    #1;
    check("rst_clk_level", 64'(clk_level), 64'(0));
    check("rst_ce_rise", 64'(ce_rise), 64'(0));
    check("rst_ce_fall", 64'(ce_fall), 64'(0));
    check("rst_stopped", 64'(stopped), 64'(0));
    check("rst_div_active", 64'(div_active), 64'h0000_ffff);

    // Release: first rise after RESET_DIV+1, high phase still on 255, then div 3.
    @(negedge sd_clk_in);
    sd_rst_n = 1'b1;
    wait_strobe(0, 1'b1, n); check("first_rise_cycles", 64'(n), 64'(256));
    wait_strobe(0, 1'b0, n); check("first_high_cycles", 64'(n), 64'(256));
    wait_strobe(0, 1'b1, n); check("div3_low", 64'(n), 64'(4));
    wait_strobe(0, 1'b0, n); check("div3_high", 64'(n), 64'(4));
    wait_strobe(0, 1'b1, n); check("div3_low2", 64'(n), 64'(4));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sd_clk_in);
      #1;
      if (ce_rise[1] ^ ce_fall[1]) cnt++;
    end
    check("ch1_div0_strobes_per_cycle", 64'(cnt), 64'(8));

    // Divisor change two cycles into a high phase: current period unaffected.
    wait_strobe(0, 1'b1, n);
    repeat (2) @(posedge sd_clk_in);
    #1;
    div_in[DB-1:0] = 8'd1;
    wait_strobe(0, 1'b0, n); check("midchg_high_rest", 64'(n), 64'(2));
    wait_strobe(0, 1'b1, n); check("midchg_new_low", 64'(n), 64'(2));
    wait_strobe(0, 1'b0, n); check("midchg_new_high", 64'(n), 64'(2));

    // Divisor table.
    for (int i = 0; i < 5; i++) begin
      div_in = {tbl[i].d1, tbl[i].d0};
      for (int c = 0; c < CH; c++) begin
        int per;
        per = (c == 0) ? tbl[i].per0 : tbl[i].per1;
        wait_strobe(c, 1'b0, n);
        wait_strobe(c, 1'b1, lo);
        wait_strobe(c, 1'b0, hi);
        check("tbl_low", 64'(lo), 64'(per / 2));
        check("tbl_high", 64'(hi), 64'(per / 2));
        check("tbl_div_active", 64'(div_active[c*DB +: DB]),
              64'((c == 0) ? tbl[i].d0 : tbl[i].d1));
      end
    end

    // Stop behaviour on ch0 with divisor 2.
    div_in[DB-1:0] = 8'd2;
    wait_strobe(0, 1'b0, n);
    wait_strobe(0, 1'b1, n);
    stop_req[0] = 1'b1;
    wait_strobe(0, 1'b0, n); check("stop_high_completes", 64'(n), 64'(3));
`ifdef SDC_CLKDIV_STOP_EN
    repeat (3) @(posedge sd_clk_in);
    #1;
    check("stop_parked", 64'(stopped[0]), 64'(1));
    check("stop_level_low", 64'(clk_level[0]), 64'(0));
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sd_clk_in);
      #1;
      if (ce_rise[0] || clk_level[0]) cnt++;
    end
    check("stop_no_rise", 64'(cnt), 64'(0));
    stop_req[0] = 1'b0;
    @(posedge sd_clk_in);
    #1;
    check("stop_released", 64'(stopped[0]), 64'(0));
    wait_strobe(0, 1'b1, n); check("restart_low", 64'(n), 64'(3));
    // One-cycle stop pulse in the high phase is cancelled before the park point.
    stop_req[0] = 1'b1;
    @(posedge sd_clk_in);
    #1;
    stop_req[0] = 1'b0;
    wait_strobe(0, 1'b0, n); check("pulse_high", 64'(n), 64'(2));
    wait_strobe(0, 1'b1, n); check("pulse_low", 64'(n), 64'(3));
`else
    wait_strobe(0, 1'b1, n); check("stop_ignored_low", 64'(n), 64'(3));
    check("stop_ignored_stopped", 64'(stopped), 64'(0));
    stop_req[0] = 1'b0;
`endif

    // Asynchronous reset in the middle of a high phase.
    div_in[DB-1:0] = 8'd3;
    wait_strobe(0, 1'b0, n);
    wait_strobe(0, 1'b1, n);
    @(posedge sd_clk_in);
    #3 sd_rst_n = 1'b0;
    #1;
    check("arst_clk_level", 64'(clk_level), 64'(0));
    check("arst_strobes", 64'({ce_rise, ce_fall}), 64'(0));
    check("arst_stopped", 64'(stopped), 64'(0));
    check("arst_div_active", 64'(div_active), 64'h0000_ffff);
    @(negedge sd_clk_in);
    sd_rst_n = 1'b1;

    // Randomized divisor and stop activity, checked by the monitor.
    repeat (3000) begin
      @(posedge sd_clk_in);
      #1;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) div_in[c*DB +: DB] = DB'($urandom_range(0, 6));
        if ($urandom_range(0, 7) == 0) stop_req[c] = ~stop_req[c];
      end
    end
    stop_req = '0;
    repeat (20) @(posedge sd_clk_in);
    @(negedge sd_clk_in);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
